hazard_ctrl: RTL

//  Parametrised pipeline hazard controller for the 5-stage F/D/E/M/W core. Compares register addresses internally for NSRC

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_fwd_sel.sv | 27 ++
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Operand source for an E-stage read: register file, W result or M result
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Controller state: normal flow, load-use bubbling, data-memory freeze
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LDBUB = 2'd1,
        MWAIT = 2'd2
    } hz_state_t;

    // The bubble counter is 3 bits wide
    localparam int LD_BUB_MAX = 7;

    // Keep the requested bubble count inside what the counter can hold
    function automatic int clamp_ld_bub(input int n);
        if (n < 1)
            return 1;
        else if (n > LD_BUB_MAX)
            return LD_BUB_MAX;
        else
            return n;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand forwarding priority selector (M result beats W result).
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of the current E/M/W addresses.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REGW = 4
) (
    input  logic [REGW-1:0] i_ra,
    input  logic            i_rvld,
    input  logic [REGW-1:0] i_wa_m,
    input  logic            i_we_m,
    input  logic [REGW-1:0] i_wa_w,
    input  logic            i_we_w,
    output fwd_sel_t        o_sel
);

    // Youngest producer wins; an operand that is not read never forwards
    always_comb begin
        o_sel = FWD_RF;
        if (i_rvld && i_we_m && (i_ra == i_wa_m))
            o_sel = FWD_M;
        else if (i_rvld && i_we_w && (i_ra == i_wa_w))
            o_sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use bubbles, memory-wait freeze. Optional perf counters: HAZARD_PERF_CNT_EN.
// Latency: forwarding and stall/flush outputs are combinational; bubble/wait sequencing is tracked in registered state.
// Backpressure: a pending data-memory access freezes F..M and flushes W; control flushes seen meanwhile are deferred.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NSRC   = 3,
    parameter int REGW   = 4,
    parameter int LD_BUB = 1,
    parameter int CNTW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*REGW-1:0] RAD,
    input  logic [NSRC-1:0]      RVldD,
    input  logic [NSRC*REGW-1:0] RAE,
    input  logic [NSRC-1:0]      RVldE,
    input  logic [REGW-1:0]      WA3E,
    input  logic [REGW-1:0]      WA3M,
    input  logic [REGW-1:0]      WA3W,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegE,
    input  logic                 MemWriteE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    input  logic                 BranchTakenD,
    input  logic                 PCSrcW,
    input  logic                 PCWrPendingF,
    output logic [NSRC*2-1:0]    ForwardE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [CNTW-1:0]      PerfStall,
    output logic [CNTW-1:0]      PerfBubble,
    output logic [CNTW-1:0]      PerfMemWait
);

    localparam int           LD_BUB_C  = clamp_ld_bub(LD_BUB);
    localparam logic [2:0]   LD_BUB_M1 = 3'(LD_BUB_C - 1);

    hz_state_t  r_state, w_state_nxt;
    hz_state_t  r_ret_state, w_ret_nxt;
    logic [2:0] r_bub_cnt, w_bub_cnt_nxt;
    logic       r_pend_flush_d;
    logic       w_ld_hit, w_ld_use, w_mem_wait, w_bubble;
    fwd_sel_t   w_fwd [NSRC];

    // One priority selector per E-stage operand; reset forces register-file reads
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd
        hazard_fwd_sel #(.REGW(REGW)) u_sel (
            .i_ra   (RAE[gi*REGW +: REGW]),
            .i_rvld (RVldE[gi]),
            .i_wa_m (WA3M),
            .i_we_m (RegWriteM),
            .i_wa_w (WA3W),
            .i_we_w (RegWriteW),
            .o_sel  (w_fwd[gi])
        );
        assign ForwardE[gi*2 +: 2] = reset ? FWD_RF : w_fwd[gi];
    end

    // Any D-stage operand that is read and matches the E destination
    always_comb begin
        w_ld_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (RVldD[i] && (RAD[i*REGW +: REGW] == WA3E))
                w_ld_hit = 1'b1;
        end
    end

    // Stores never produce a register result, so they cannot cause load-use
    assign w_ld_use   = w_ld_hit & RegWriteE & MemtoRegE & ~MemWriteE;
    assign w_mem_wait = MemReqM & ~MemReadyM;

    // Next-state: a memory wait always wins and parks the bubble counter
    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret_state;
        w_bub_cnt_nxt = r_bub_cnt;
        w_bubble      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt = MWAIT;
                    w_ret_nxt   = RUN;
                end else if (w_ld_use) begin
                    w_bubble      = 1'b1;
                    w_bub_cnt_nxt = LD_BUB_M1;
                    w_state_nxt   = (LD_BUB_C > 1) ? LDBUB : RUN;
                end
            end
            LDBUB: begin
                // A new load-use here is ignored: the load already left E
                if (w_mem_wait) begin
                    w_state_nxt = MWAIT;
                    w_ret_nxt   = LDBUB;
                end else begin
                    w_bubble      = 1'b1;
                    w_bub_cnt_nxt = r_bub_cnt - 3'd1;
                    if (r_bub_cnt <= 3'd1)
                        w_state_nxt = RUN;
                end
            end
            MWAIT: begin
                if (!w_mem_wait)
                    w_state_nxt = r_ret_state;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // State, saved return state and bubble counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_bub_cnt   <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_bub_cnt   <= w_bub_cnt_nxt;
        end
    end

    // A PC write retiring during a freeze must flush D once the pipe moves again
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pend_flush_d <= 1'b0;
        else if (w_mem_wait)
            r_pend_flush_d <= r_pend_flush_d | PCSrcW;
        else
            r_pend_flush_d <= 1'b0;
    end

    // While reset is high every pipe register is flushed and none is held
    assign StallF = ~reset & (w_mem_wait | w_bubble | PCWrPendingF);
    assign StallD = ~reset & (w_mem_wait | w_bubble);
    assign StallE = ~reset & w_mem_wait;
    assign StallM = ~reset & w_mem_wait;
    assign FlushE = reset | w_bubble;
    assign FlushW = reset | w_mem_wait;
    assign FlushD = reset |
                    ((BranchTakenD | PCSrcW | PCWrPendingF | r_pend_flush_d) & ~w_mem_wait);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNTW-1:0] r_perf_stall, r_perf_bubble, r_perf_mwait;

    // Saturating event counters for D stalls, load-use bubbles and memory-wait cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
            r_perf_mwait  <= '0;
        end else begin
            if (StallD && !(&r_perf_stall))
                r_perf_stall <= r_perf_stall + CNTW'(1);
            if (w_bubble && !(&r_perf_bubble))
                r_perf_bubble <= r_perf_bubble + CNTW'(1);
            if (w_mem_wait && !(&r_perf_mwait))
                r_perf_mwait <= r_perf_mwait + CNTW'(1);
        end
    end

    assign PerfStall   = r_perf_stall;
    assign PerfBubble  = r_perf_bubble;
    assign PerfMemWait = r_perf_mwait;
`else
    assign PerfStall   = '0;
    assign PerfBubble  = '0;
    assign PerfMemWait = '0;
`endif

endmodule
